// File: rtl/mac_link_pkg.sv
// ============================================================================
// Module   : mac_link_pkg
// Brief    : Shared opcodes, FSM state encoding and widths for the MAC link host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_link_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    localparam logic [1:0] OP_NOP       = 2'b00;
    localparam logic [1:0] OP_MAC       = 2'b01;
    localparam logic [1:0] OP_READ      = 2'b10;
    localparam logic [1:0] OP_LOAD_HIGH = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MAC_STB = 3'd1,
        LD_DRV  = 3'd2,
        LD_STB  = 3'd3,
        LD_REL  = 3'd4,
        RD_ON   = 3'd5,
        RD_REL  = 3'd6,
        RESP    = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mac_link_shadow.sv
// ============================================================================
// Module   : mac_link_shadow
// Brief    : Shadow accumulator mirroring the MAC tile; compares against each
//            captured READ value. Only used when MAC_LINK_SHADOW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_link_shadow
    import mac_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mac_fire_i,
    input  logic              ld_fire_i,
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              cap_i,
    input  logic [WORD_W-1:0] cap_data_i,
    output logic              mismatch_o
);

    logic [WORD_W-1:0] shadow_q;
    logic [WORD_W-1:0] shadow_d;
    logic [WORD_W-1:0] w_prod;

    assign w_prod     = WORD_W'(a_i) * WORD_W'(b_i);
    assign mismatch_o = (cap_data_i != shadow_q);

    // A capture resynchronises the shadow to what the tile actually holds.
    always_comb begin
        shadow_d = shadow_q;
        if (cap_i) begin
            shadow_d = cap_data_i;
        end else if (mac_fire_i) begin
            shadow_d = shadow_q + w_prod;
        end else if (ld_fire_i) begin
            shadow_d = {a_i, shadow_q[BYTE_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mac_link_host.sv
// ============================================================================
// Module   : mac_link_host
// Brief    : Host-side sequencer for the 8-bit-pad MAC tile; owns the shared
//            high-byte pad with turnaround. Optional: MAC_LINK_SHADOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_link_host
    import mac_link_pkg::*;
#(
    parameter int TURN_CYC   = 1,
    parameter int SAMPLE_DLY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [BYTE_W-1:0] cmd_a,
    input  logic [BYTE_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_mismatch,
    output logic              busy,
    output logic [BYTE_W-1:0] mac_in_a,
    output logic [BYTE_W-1:0] mac_in_b,
    output logic              mac_acc_en,
    output logic              mac_io_drive,
    output logic              mac_load_ext_high,
    input  logic [BYTE_W-1:0] mac_out_low,
    input  logic [BYTE_W-1:0] pad_high_i,
    output logic [BYTE_W-1:0] pad_high_o,
    output logic              pad_high_oe
);

    localparam int CNT_MAX = (TURN_CYC > SAMPLE_DLY) ? TURN_CYC : SAMPLE_DLY;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_TURN_LAST   = CNT_W'(TURN_CYC - 1);
    // The first RD_ON cycle is the grant itself; io_drive is then held
    // SAMPLE_DLY further cycles before the pad is sampled.
    localparam logic [CNT_W-1:0] C_SAMPLE_LAST = CNT_W'(SAMPLE_DLY);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] a_q, a_d;
    logic [BYTE_W-1:0] b_q, b_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
    logic              mism_q, mism_d;

    logic              w_cmd_fire;
    logic              w_capture;
    logic              w_shadow_mism;
    logic [WORD_W-1:0] w_cap_data;

    assign w_cmd_fire = cmd_valid && (state_q == IDLE);
    assign w_capture  = (state_q == RD_ON) && (cnt_q == '0);
    assign w_cap_data = {pad_high_i, mac_out_low};

`ifdef MAC_LINK_SHADOW_EN
    mac_link_shadow u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .mac_fire_i (w_cmd_fire && (cmd_op == OP_MAC)),
        .ld_fire_i  (w_cmd_fire && (cmd_op == OP_LOAD_HIGH)),
        .a_i        (cmd_a),
        .b_i        (cmd_b),
        .cap_i      (w_capture),
        .cap_data_i (w_cap_data),
        .mismatch_o (w_shadow_mism)
    );
`else
    assign w_shadow_mism = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        rsp_data_d = rsp_data_q;
        mism_d     = mism_q;

        cmd_ready         = 1'b0;
        busy              = 1'b1;
        rsp_valid         = 1'b0;
        mac_acc_en        = 1'b0;
        mac_io_drive      = 1'b0;
        mac_load_ext_high = 1'b0;
        pad_high_o        = '0;
        pad_high_oe       = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (w_cmd_fire) begin
                    case (cmd_op)
                        OP_MAC: begin
                            a_d     = cmd_a;
                            b_d     = cmd_b;
                            state_d = MAC_STB;
                        end
                        OP_READ: begin
                            cnt_d   = C_SAMPLE_LAST;
                            state_d = RD_ON;
                        end
                        OP_LOAD_HIGH: begin
                            hi_d    = cmd_a;
                            state_d = LD_DRV;
                        end
                        default: ;
                    endcase
                end
            end
            MAC_STB: begin
                mac_acc_en = 1'b1;
                state_d    = IDLE;
            end
            LD_DRV: begin
                pad_high_oe = 1'b1;
                pad_high_o  = hi_q;
                state_d     = LD_STB;
            end
            LD_STB: begin
                pad_high_oe       = 1'b1;
                pad_high_o        = hi_q;
                mac_load_ext_high = 1'b1;
                cnt_d             = C_TURN_LAST;
                state_d           = LD_REL;
            end
            LD_REL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_ON: begin
                mac_io_drive = 1'b1;
                if (w_capture) begin
                    rsp_data_d = w_cap_data;
                    mism_d     = w_shadow_mism;
                    cnt_d      = C_TURN_LAST;
                    state_d    = RD_REL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_REL: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            rsp_data_q <= '0;
            mism_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            rsp_data_q <= rsp_data_d;
            mism_q     <= mism_d;
        end
    end

    assign mac_in_a     = a_q;
    assign mac_in_b     = b_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_mismatch = mism_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_link_host.sv
// ============================================================================
// Module   : tb_mac_link_host
// Brief    : Directed self-checking bench for mac_link_host with a behavioural
//            MAC tile; a second instance runs TURN_CYC=3, SAMPLE_DLY=2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_link_host;
    import mac_link_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst_n;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_mismatch, busy;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a, cmd_b, mac_in_a, mac_in_b, mac_out_low, pad_high_i, pad_high_o;
    logic [15:0] rsp_data;
    logic        mac_acc_en, mac_io_drive, mac_load_ext_high, pad_high_oe;

    logic        t3_cmd_valid, t3_cmd_ready, t3_rsp_valid, t3_rsp_mismatch, t3_busy;
    logic [1:0]  t3_cmd_op;
    logic [7:0]  t3_cmd_a, t3_in_a, t3_in_b, t3_out_low, t3_pad_i, t3_pad_o;
    logic [15:0] t3_rsp_data;
    logic        t3_acc_en, t3_io_drive, t3_load_high, t3_oe;

    mac_link_host #(.TURN_CYC(1), .SAMPLE_DLY(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_mismatch(rsp_mismatch),
        .busy(busy), .mac_in_a(mac_in_a), .mac_in_b(mac_in_b), .mac_acc_en(mac_acc_en),
        .mac_io_drive(mac_io_drive), .mac_load_ext_high(mac_load_ext_high),
        .mac_out_low(mac_out_low), .pad_high_i(pad_high_i), .pad_high_o(pad_high_o),
        .pad_high_oe(pad_high_oe)
    );

    mac_link_host #(.TURN_CYC(3), .SAMPLE_DLY(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(t3_cmd_valid), .cmd_ready(t3_cmd_ready),
        .cmd_op(t3_cmd_op), .cmd_a(t3_cmd_a), .cmd_b(8'h00), .rsp_valid(t3_rsp_valid),
        .rsp_ready(1'b1), .rsp_data(t3_rsp_data), .rsp_mismatch(t3_rsp_mismatch),
        .busy(t3_busy), .mac_in_a(t3_in_a), .mac_in_b(t3_in_b), .mac_acc_en(t3_acc_en),
        .mac_io_drive(t3_io_drive), .mac_load_ext_high(t3_load_high),
        .mac_out_low(t3_out_low), .pad_high_i(t3_pad_i), .pad_high_o(t3_pad_o),
        .pad_high_oe(t3_oe)
    );

    // Behavioural MAC tiles sharing the pad with the host
    logic [15:0] acc, acc3;
    logic        force_ff;
    logic [7:0]  w_pad, w_pad3;
    assign w_pad       = mac_io_drive ? acc[15:8] : (pad_high_oe ? pad_high_o : 8'h00);
    assign pad_high_i  = force_ff ? 8'hFF : w_pad;
    assign mac_out_low = acc[7:0];
    assign w_pad3      = t3_io_drive ? acc3[15:8] : (t3_oe ? t3_pad_o : 8'h00);
    assign t3_pad_i    = w_pad3;
    assign t3_out_low  = acc3[7:0];

    always @(posedge clk) begin
        if (!rst_n) acc <= 16'h0000;
        else if (mac_acc_en) acc <= acc + {8'h00, mac_in_a} * {8'h00, mac_in_b};
        else if (mac_load_ext_high) acc[15:8] <= w_pad;
    end

    always @(posedge clk) begin
        if (!rst_n) acc3 <= 16'h0000;
        else if (t3_acc_en) acc3 <= acc3 + {8'h00, t3_in_a} * {8'h00, t3_in_b};
        else if (t3_load_high) acc3[15:8] <= w_pad3;
    end

    // Pad ownership monitors: never both drivers, >=TURN_CYC dead cycles between owners
    int gap1, gap3;
    int own1, own3;
    always @(negedge clk) begin
        if (!rst_n) begin
            gap1 = 100; own1 = 0;
        end else if (pad_high_oe && mac_io_drive) begin
            errors++;
            $display("FAIL pad_overlap1 oe=%b io_drive=%b expected not both 1", pad_high_oe, mac_io_drive);
        end else if (pad_high_oe || mac_io_drive) begin
            if (cmd_ready) begin
                errors++;
                $display("FAIL pad_idle1 oe=%b io_drive=%b expected 0 in IDLE", pad_high_oe, mac_io_drive);
            end
            if (own1 != 0 && own1 != (pad_high_oe ? 1 : 2)) begin
                checks++;
                if (gap1 < 1) begin
                    errors++;
                    $display("FAIL pad_turn1 gap=%0d expected >=1", gap1);
                end
            end
            own1 = pad_high_oe ? 1 : 2;
            gap1 = 0;
        end else begin
            gap1++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            gap3 = 100; own3 = 0;
        end else if (t3_oe && t3_io_drive) begin
            errors++;
            $display("FAIL pad_overlap3 oe=%b io_drive=%b expected not both 1", t3_oe, t3_io_drive);
        end else if (t3_oe || t3_io_drive) begin
            if (own3 != 0 && own3 != (t3_oe ? 1 : 2)) begin
                checks++;
                if (gap3 < 3) begin
                    errors++;
                    $display("FAIL pad_turn3 gap=%0d expected >=3", gap3);
                end
            end
            own3 = t3_oe ? 1 : 2;
            gap3 = 0;
        end else begin
            gap3++;
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL cmd_accept_timeout cmd_ready=%b expected 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = OP_NOP;
    endtask

    // Returns the response and the number of edges from accept to rsp_valid (-1 on timeout)
    task automatic do_read(output logic [15:0] d, output logic m, output int lat);
        send_cmd(OP_READ, 8'h00, 8'h00);
        lat = -1; d = 16'hxxxx; m = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin
                lat = k; d = rsp_data; m = rsp_mismatch;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_a = 8'h00; cmd_b = 8'h00;
        rsp_ready = 1'b1; force_ff = 1'b0;
        t3_cmd_valid = 1'b0; t3_cmd_op = OP_NOP; t3_cmd_a = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, busy, rsp_valid, mac_acc_en, mac_io_drive, mac_load_ext_high, pad_high_oe} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 1000000",
                     {cmd_ready, busy, rsp_valid, mac_acc_en, mac_io_drive, mac_load_ext_high, pad_high_oe});
        end
        checks++;
        if ({mac_in_a, mac_in_b, rsp_data, pad_high_o, rsp_mismatch} !== 41'd0) begin
            errors++;
            $display("FAIL reset_data in_a=%h in_b=%h rsp=%h pad_o=%h mm=%b expected all 0",
                     mac_in_a, mac_in_b, rsp_data, pad_high_o, rsp_mismatch);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_zero();
        logic [15:0] d; logic m; int lat;
        do_read(d, m, lat);
        checks++;
        if (d !== 16'h0000 || m !== 1'b0) begin
            errors++;
            $display("FAIL read_zero data=%h mm=%b expected 0000 0", d, m);
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL read_latency got %0d expected 3", lat);
        end
    endtask

    task automatic test_mac();
        logic [15:0] d; logic m; int lat;
        send_cmd(OP_NOP, 8'h11, 8'h22);
        checks++;
        if (busy !== 1'b0 || mac_acc_en !== 1'b0 || mac_in_a !== 8'h00) begin
            errors++;
            $display("FAIL nop busy=%b acc_en=%b in_a=%h expected 0 0 00", busy, mac_acc_en, mac_in_a);
        end
        send_cmd(OP_MAC, 8'd3, 8'd5);
        checks++;
        if (mac_acc_en !== 1'b1 || mac_in_a !== 8'd3 || mac_in_b !== 8'd5) begin
            errors++;
            $display("FAIL mac1_strobe acc_en=%b a=%0d b=%0d expected 1 3 5", mac_acc_en, mac_in_a, mac_in_b);
        end
        @(posedge clk); #1;
        checks++;
        if (mac_acc_en !== 1'b0 || mac_in_a !== 8'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mac1_pulse acc_en=%b a=%0d busy=%b expected 0 3 0", mac_acc_en, mac_in_a, busy);
        end
        send_cmd(OP_MAC, 8'd10, 8'd20);
        checks++;
        if (mac_acc_en !== 1'b1 || mac_in_a !== 8'd10 || mac_in_b !== 8'd20) begin
            errors++;
            $display("FAIL mac2_strobe acc_en=%b a=%0d b=%0d expected 1 10 20", mac_acc_en, mac_in_a, mac_in_b);
        end
        @(posedge clk); #1;
        checks++;
        if (mac_acc_en !== 1'b0) begin
            errors++;
            $display("FAIL mac2_pulse acc_en=%b expected 0", mac_acc_en);
        end
        do_read(d, m, lat);
        checks++;
        if (d !== 16'h00D7 || lat != 3) begin
            errors++;
            $display("FAIL mac_read data=%h lat=%0d expected 00d7 3", d, lat);
        end
    endtask

    task automatic test_load_high();
        logic [15:0] d; logic m; int lat;
        send_cmd(OP_LOAD_HIGH, 8'hA5, 8'h00);
        checks++;
        if (pad_high_oe !== 1'b1 || pad_high_o !== 8'hA5 || mac_load_ext_high !== 1'b0) begin
            errors++;
            $display("FAIL ld_drv oe=%b pad_o=%h load=%b expected 1 a5 0", pad_high_oe, pad_high_o, mac_load_ext_high);
        end
        @(posedge clk); #1;
        checks++;
        if (pad_high_oe !== 1'b1 || mac_load_ext_high !== 1'b1 || mac_acc_en !== 1'b0) begin
            errors++;
            $display("FAIL ld_stb oe=%b load=%b acc_en=%b expected 1 1 0", pad_high_oe, mac_load_ext_high, mac_acc_en);
        end
        @(posedge clk); #1;
        checks++;
        if (pad_high_oe !== 1'b0 || mac_load_ext_high !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ld_rel oe=%b load=%b busy=%b expected 0 0 1", pad_high_oe, mac_load_ext_high, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ld_done busy=%b expected 0", busy);
        end
        do_read(d, m, lat);
        checks++;
        if (d !== 16'hA5D7) begin
            errors++;
            $display("FAIL ld_read data=%h expected a5d7", d);
        end
    endtask

    task automatic test_back_to_back_stall();
        int n;
        @(negedge clk);
        rsp_ready = 1'b0;
        send_cmd(OP_READ, 8'h00, 8'h00);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5D7) begin
            errors++;
            $display("FAIL stall_rsp valid=%b data=%h expected 1 a5d7", rsp_valid, rsp_data);
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_MAC; cmd_a = 8'd1; cmd_b = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5D7 || cmd_ready !== 1'b0 || mac_acc_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d valid=%b data=%h ready=%b acc_en=%b expected 1 a5d7 0 0",
                         i, rsp_valid, rsp_data, cmd_ready, mac_acc_en);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release valid=%b ready=%b expected 0 1", rsp_valid, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = OP_NOP;
        checks++;
        if (mac_acc_en !== 1'b1 || mac_in_a !== 8'd1) begin
            errors++;
            $display("FAIL stall_cmd acc_en=%b a=%0d expected 1 1", mac_acc_en, mac_in_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [15:0] d; logic m; int lat;
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        send_cmd(OP_MAC, 8'd255, 8'd255);
        send_cmd(OP_MAC, 8'd255, 8'd255);
        @(posedge clk); #1;
        do_read(d, m, lat);
        checks++;
        if (d !== 16'hFC02) begin
            errors++;
            $display("FAIL wrap_read data=%h expected fc02", d);
        end
    endtask

    task automatic test_reset_mid();
        send_cmd(OP_READ, 8'h00, 8'h00);
        checks++;
        if (mac_io_drive !== 1'b1) begin
            errors++;
            $display("FAIL rdon_drive io_drive=%b expected 1", mac_io_drive);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mac_io_drive !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort io=%b valid=%b ready=%b busy=%b expected 0 0 1 0",
                     mac_io_drive, rsp_valid, cmd_ready, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard cyc=%0d rsp_valid=%b expected 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_shadow();
        logic [15:0] d; logic m; int lat;
        logic exp_m;
`ifdef MAC_LINK_SHADOW_EN
        exp_m = 1'b1;
`else
        exp_m = 1'b0;
`endif
        send_cmd(OP_MAC, 8'd3, 8'd5);
        send_cmd(OP_MAC, 8'd10, 8'd20);
        @(posedge clk); #1;
        force_ff = 1'b1;
        do_read(d, m, lat);
        checks++;
        if (d !== 16'hFFD7 || m !== exp_m) begin
            errors++;
            $display("FAIL shadow_mismatch data=%h mm=%b expected ffd7 %b", d, m, exp_m);
        end
        do_read(d, m, lat);
        checks++;
        if (d !== 16'hFFD7 || m !== 1'b0) begin
            errors++;
            $display("FAIL shadow_resync data=%h mm=%b expected ffd7 0", d, m);
        end
        force_ff = 1'b0;
    endtask

    task automatic test_turn3();
        int lat;
        logic [15:0] d;
        @(negedge clk);
        t3_cmd_valid = 1'b1; t3_cmd_op = OP_LOAD_HIGH; t3_cmd_a = 8'h3C;
        @(posedge clk); #1;
        t3_cmd_valid = 1'b0;
        checks++;
        if (t3_oe !== 1'b1 || t3_pad_o !== 8'h3C) begin
            errors++;
            $display("FAIL t3_ld_drv oe=%b pad_o=%h expected 1 3c", t3_oe, t3_pad_o);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (t3_busy !== 1'b1 || t3_oe !== 1'b0) begin
            errors++;
            $display("FAIL t3_ld_rel busy=%b oe=%b expected 1 0", t3_busy, t3_oe);
        end
        @(posedge clk); #1;
        checks++;
        if (t3_busy !== 1'b0) begin
            errors++;
            $display("FAIL t3_ld_done busy=%b expected 0", t3_busy);
        end
        @(negedge clk);
        t3_cmd_valid = 1'b1; t3_cmd_op = OP_READ;
        @(posedge clk); #1;
        t3_cmd_valid = 1'b0; t3_cmd_op = OP_NOP;
        lat = -1; d = 16'hxxxx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (t3_rsp_valid === 1'b1) begin
                lat = k; d = t3_rsp_data;
                break;
            end
        end
        checks++;
        if (lat != 6 || d !== 16'h3C00) begin
            errors++;
            $display("FAIL t3_read lat=%0d data=%h expected 6 3c00", lat, d);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_read_zero();
        test_mac();
        test_load_high();
        test_back_to_back_stall();
        test_wrap();
        test_reset_mid();
        test_shadow();
        test_turn3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
